piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, word length in bits; SHALL be legal for any WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: parallelIn  input  WIDTH  word to serialize.
REQ-005 Port: loadValid  input  1  parallelIn holds a word to send.
REQ-006 Port: loadReady  output  1  block can accept a word this cycle.
REQ-007 Port: hold  input  1  stall request; freezes shifting while high.
REQ-008 Port: serialOut  output  1  serial data line, LSB first, registered.
REQ-009 Port: frameActive  output  1  high while serialOut carries a valid data bit, registered.
REQ-010 Port: done  output  1  one-cycle pulse after the last bit of a word, registered.

Function
REQ-011 The block SHALL feed a downstream negedge-sampling shift-in register, so serialOut changes only on rising edges and is stable across each falling edge.
REQ-012 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-013 The block SHALL keep a shift register shiftReg[WIDTH-1:0] and a bit counter count of ceil(log2(WIDTH)) bits.
REQ-014 loadReady SHALL be high when state==IDLE, or when state==SHIFT and count==WIDTH-1 and hold==0; it SHALL be low otherwise.
REQ-015 A handshake SHALL occur on a rising edge where loadValid and loadReady are both high.
- On a handshake: shiftReg <= parallelIn, count <= 0, serialOut <= parallelIn[0], frameActive <= 1, state <= SHIFT.
REQ-016 In SHIFT with hold==0 and count < WIDTH-1: shiftReg SHALL shift right by one, count SHALL increment, and serialOut SHALL take the next bit.
- serialOut SHALL carry word bits 0..WIDTH-1 on WIDTH consecutive cycles.
REQ-017 In SHIFT with hold==1: shiftReg, count, serialOut, frameActive and state SHALL all hold their values, and done SHALL be 0.
REQ-018 In SHIFT with hold==0 and count==WIDTH-1, done SHALL be 1 on the next cycle.
- With a handshake: the new word SHALL start with no gap (REQ-015), and the state SHALL stay SHIFT.
- Without a handshake: the state SHALL go to IDLE, with serialOut <= 0 and frameActive <= 0.
REQ-019 done SHALL be 0 in every cycle not covered by REQ-018.
REQ-020 In IDLE with no handshake: serialOut SHALL be 0, frameActive SHALL be 0, and hold SHALL be ignored.
REQ-021 While loadReady is low, loadValid SHALL be ignored: no capture and no state change.
REQ-022 Latency: from the handshake edge to the first bit on serialOut SHALL be 0 cycles (the bit is valid right after that edge).
- Frame length SHALL be WIDTH cycles plus the number of cycles with hold high.

Reset
REQ-023 While rst is low, asynchronously: state=IDLE, shiftReg=0, count=0, serialOut=0, frameActive=0, done=0; loadReady SHALL then read 1.
REQ-024 A reset asserted mid-frame SHALL abort the frame with no done pulse.
- The first rising edge after rst rises SHALL behave as IDLE.

Verification (WIDTH=4)
REQ-025 Reset, then a single handshake with parallelIn=4'b1011 -> serialOut 1,1,0,1 on 4 consecutive cycles; frameActive high for exactly 4 cycles; done pulses on the 5th cycle; loadReady low during the first 3 bits; a downstream shift-in register reads 4'b1011.
REQ-026 Back-to-back: 4'hA then 4'h5 with loadValid held high -> serialOut 0,1,0,1,1,0,1,0 with frameActive continuously high for 8 cycles; done pulses after each word.
REQ-027 4'b0110 with hold high for 2 cycles during bit 1 -> bit 1 (value 1) lasts 3 cycles; frame lasts 6 cycles; one done pulse.
REQ-028 rst driven low after 2 bits of 4'hF -> serialOut=0 and frameActive=0 immediately; no done; after release, 4'h3 serializes cleanly as 1,1,0,0.
REQ-029 loadValid with 4'h9 pulsed during bit 1 of 4'h6 -> 4'h9 not captured; serialOut shows only 0,1,1,0 followed by idle 0.

Source files
------------

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out shifter with a valid/ready load handshake.
//   A word is shifted out LSB first, one bit per clock, with serialOut updated
//   on rising edges only so a downstream negedge-sampling register sees a stable
//   bit. A new word can be accepted on the last bit of the current one, giving
//   gap-free back-to-back frames.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   parallelIn   word to serialize
//   loadValid    parallelIn holds a word to send
//   loadReady    word can be accepted this cycle (combinational)
//   hold         freezes shifting while high (ignored when idle)
//   serialOut    registered serial data, LSB first
//   frameActive  registered, high while serialOut carries a data bit
//   done         registered one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic             hold,
    output logic             serialOut,
    output logic             frameActive,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             serial_q,    serial_d;
    logic             frame_q,     frame_d;
    logic             done_q,      done_d;

    logic last_bit;
    logic load_ready;
    logic handshake;

    // The bit currently on serialOut is always shift_reg_q[0]; the register is
    // cleared when a frame ends, so serialOut is simply bit 0 of the next value.
    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        count_d     = count_q;
        frame_d     = frame_q;
        done_d      = 1'b0;

        last_bit   = (state_q == SHIFT) && (count_q == LAST) && !hold;
        load_ready = (state_q == IDLE) || last_bit;
        handshake  = loadValid && load_ready;

        // The final bit completes regardless of whether a new word follows.
        if (last_bit) begin
            done_d = 1'b1;
        end

        if (handshake) begin
            state_d     = SHIFT;
            shift_reg_d = parallelIn;
            count_d     = '0;
            frame_d     = 1'b1;
        end else if (state_q == SHIFT && !hold) begin
            if (count_q == LAST) begin
                state_d     = IDLE;
                shift_reg_d = '0;
                count_d     = '0;
                frame_d     = 1'b0;
            end else begin
                shift_reg_d = {1'b0, shift_reg_q[WIDTH-1:1]};
                count_d     = count_q + CW'(1);
            end
        end else if (state_q == IDLE) begin
            shift_reg_d = '0;
            frame_d     = 1'b0;
        end

        serial_d = shift_reg_d[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            count_q     <= '0;
            serial_q    <= 1'b0;
            frame_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            count_q     <= count_d;
            serial_q    <= serial_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
        end
    end

    assign loadReady   = load_ready;
    assign serialOut   = serial_q;
    assign frameActive = frame_q;
    assign done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed vector tables for the WIDTH=4 corner cases (single word,
//   back-to-back, hold, ignored load, mid-frame reset) followed by randomized
//   traffic checked against a queue-based model of the bit stream.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] parallelIn = '0;
    logic             loadValid = 1'b0;
    logic             loadReady;
    logic             hold = 1'b0;
    logic             serialOut;
    logic             frameActive;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [WIDTH-1:0] ds_reg = '0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .parallelIn  (parallelIn),
        .loadValid   (loadValid),
        .loadReady   (loadReady),
        .hold        (hold),
        .serialOut   (serialOut),
        .frameActive (frameActive),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Downstream shift-in register sampling on the falling edge.
    always @(negedge clk) begin
        if (frameActive) ds_reg <= {serialOut, ds_reg[WIDTH-1:1]};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic             lv;
        logic [WIDTH-1:0] pin;
        logic             hld;
        logic             e_rdy;   // loadReady before the edge
        logic             e_ser;   // outputs after the edge
        logic             e_fa;
        logic             e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: act=%0d req=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge (+1); drives inputs, checks loadReady,
    // advances one edge, then checks the registered outputs.
    task automatic apply(input vec_t v, input string tag);
        loadValid  = v.lv;
        parallelIn = v.pin;
        hold       = v.hld;
        #3;
        chk({tag, ".loadReady"}, int'(loadReady), int'(v.e_rdy));
        @(posedge clk); #1;
        chk({tag, ".serialOut"},   int'(serialOut),   int'(v.e_ser));
        chk({tag, ".frameActive"}, int'(frameActive), int'(v.e_fa));
        chk({tag, ".done"},        int'(done),        int'(v.e_done));
    endtask

    function automatic vec_t mk(input logic lv, input logic [WIDTH-1:0] pin,
                                input logic hld, input logic rdy,
                                input logic ser, input logic fa, input logic dn);
        vec_t v;
        v.lv = lv; v.pin = pin; v.hld = hld; v.e_rdy = rdy;
        v.e_ser = ser; v.e_fa = fa; v.e_done = dn;
        return v;
    endfunction

    task automatic run_table(input string tag);
        foreach (vecs[i]) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
        vecs.delete();
    endtask

    // Reference model: the queue holds the bits still to appear on serialOut,
    // with the front being the bit currently shown.
    logic mq[$];

    task automatic model_step(input logic lv, input logic [WIDTH-1:0] pin,
                              input logic hld, output logic rdy,
                              output logic ser, output logic fa, output logic dn);
        rdy = (mq.size() == 0) || (mq.size() == 1 && !hld);
        dn  = (mq.size() == 1) && !hld;
        if (mq.size() > 0 && !hld) void'(mq.pop_front());
        if (lv && rdy) begin
            mq.delete();
            for (int b = 0; b < WIDTH; b++) mq.push_back(pin[b]);
        end
        ser = (mq.size() > 0) ? mq[0] : 1'b0;
        fa  = (mq.size() > 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #3;
        chk("rst.serialOut",   int'(serialOut),   0);
        chk("rst.frameActive", int'(frameActive), 0);
        chk("rst.done",        int'(done),        0);
        chk("rst.loadReady",   int'(loadReady),   1);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- single word 4'b1011 ----------------
        vecs.push_back(mk(1, 4'b1011, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0));  // hold ignored in idle
        run_table("single");
        chk("single.downstream", int'(ds_reg), int'(4'b1011));

        // ---------------- back-to-back 4'hA, 4'h5 ----------------
        vecs.push_back(mk(1, 4'hA, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'h5, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 4'h5, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 4'h5, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 4'h5, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0));
        run_table("b2b");

        // ---------------- hold during bit 1 of 4'b0110 ----------------
        vecs.push_back(mk(1, 4'b0110, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 0, 0, 1, 0));  // hold on last bit blocks load
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 0, 1));
        run_table("hold");

        // ---------------- 4'h9 offered during bit 1 of 4'h6 ----------------
        vecs.push_back(mk(1, 4'h6, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'h9, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 4'h9, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0));
        run_table("ignore");

        // ---------------- reset mid-frame of 4'hF ----------------
        vecs.push_back(mk(1, 4'hF, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 1, 0));
        run_table("abort");
        #2; rst = 1'b0; #1;
        chk("abort.serialOut",   int'(serialOut),   0);
        chk("abort.frameActive", int'(frameActive), 0);
        chk("abort.done",        int'(done),        0);
        chk("abort.loadReady",   int'(loadReady),   1);
        @(posedge clk); #1;
        chk("abort.done_held", int'(done), 0);
        #2; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.done_after", int'(done), 0);
        vecs.push_back(mk(1, 4'h3, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 0, 1));
        run_table("after_rst");

        // ---------------- randomized traffic vs model ----------------
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            vec_t v;
            logic r, s, f, d;
            v.lv  = ($urandom_range(0, 99) < 55);
            v.pin = WIDTH'($urandom);
            v.hld = ($urandom_range(0, 99) < 25);
            model_step(v.lv, v.pin, v.hld, r, s, f, d);
            v.e_rdy = r; v.e_ser = s; v.e_fa = f; v.e_done = d;
            apply(v, $sformatf("rand[%0d]", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
